seg_scan_controller: RTL and testbench
======================================

# seg_scan_controller

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display. It shares one `bto7s` hex decoder across all digits and steps one digit per scan period. It holds a tear-free shadow copy of a 32-bit display value plus a per-digit blank mask, and accepts updates through a valid/ready handshake. It sits between user logic producing hex values and the board's anode and cathode pins.

## Interface
- `COUNT_PERIOD`, default 100000: clock cycles each digit is lit; legal range ≥ 2.
- `LZ_BLANK`, default 0: when 1, leading-zero digits are blanked (digit 0 is never blanked by this rule).
- `clk_in` input 1: system clock; one clock domain.
- `rst_in` input 1: synchronous, active-high reset.
- `val_in` input 32: display value; nibble k drives digit k (digit 0 is rightmost).
- `blank_in` input 8: per-digit blank mask; bit k=1 forces digit k dark.
- `valid_in` input 1: update request for `val_in`/`blank_in`.
- `ready_out` output 1: high when no update is pending; a transfer occurs when `valid_in && ready_out`.
- `an_out` output 8: anode enables, active-low, one-hot-low or all-high.
- `cat_out` output 7: cathodes {g..a}, active-low; equals ~`bto7s.s_out`, or 7'h7F when the digit is blank.
- `digit_out` output 3: index of the digit currently driven (debug/ILA).

## Operation
- Period counter `cnt` runs 0..COUNT_PERIOD-1 and wraps to 0. Digit index `idx` (3 bits) increments when `cnt == COUNT_PERIOD-1`, wrapping from 7 to 0.
- Update handshake:
  - On transfer, `val_in`/`blank_in` are captured into pending registers and `ready_out` drops the next cycle.
  - The pending value is copied into the display registers on the cycle `idx` wraps 7→0, and `ready_out` returns high the same cycle.
  - A new frame therefore always starts with a fresh value and is never mixed with the old one.
- `valid_in` is ignored while `ready_out` is low. The producer holds data until the transfer.
- If a transfer and a 7→0 wrap occur in the same cycle with nothing pending, the new data is captured into pending. It is applied at the next wrap, not the current one.
- Decode path:
  - The nibble `disp_val[4*idx +: 4]` feeds a single shared `bto7s`.
  - The digit is blank if `disp_blank[idx]`, or if `LZ_BLANK` is 1, `idx != 0`, and all nibbles idx..7 are zero.
- Output registers:
  - `an_out = ~(8'b1 << idx)`.
  - `cat_out = blank ? 7'h7F : ~s_out`.
  - `digit_out = idx`.
  - All three are registered from the current `idx` and display state.
- States: IDLE (`ready_out`=1, no pending) and PENDING (`ready_out`=0). IDLE→PENDING on transfer. PENDING→IDLE on the 7→0 wrap.

## Timing
- Reset values: `cnt`=0, `idx`=0, display value=0, display mask=0, pending cleared, `ready_out`=1, `an_out`=8'hFF, `cat_out`=7'h7F, `digit_out`=0.
- Reset mid-frame or mid-pending discards the pending update with no partial apply.
- First cycle after `rst_in` falls: registers compute from `idx`=0. One cycle later, `an_out`=8'hFE and `cat_out` shows "0" (7'h40).
- Output latency is 1 cycle from an `idx` change to `an_out`/`cat_out`. `an_out` and `cat_out` always change in the same cycle, so no ghosting from skew.
- Each digit is lit for exactly COUNT_PERIOD cycles; a full frame is 8×COUNT_PERIOD cycles.
- Worst-case update latency from transfer to display: 8×COUNT_PERIOD + 1 cycles. Best case: 2 cycles (transfer on the wrap-minus-one cycle, wrap, then the output register).

## Test plan
- Reset with COUNT_PERIOD=4: hold `rst_in` for 3 cycles → `an_out`=FF and `cat_out`=7F during reset. After release, `an_out` sequences FE,FD,…,7F, each for 4 cycles, then wraps to FE; `cat_out`=7'h40 throughout.
- Update: transfer `val_in`=32'h0123_4567, `blank_in`=0 mid-frame → `ready_out` is low until the next 7→0 wrap. The following frame shows digit0=7 (`cat_out` 7'h78) … digit7=0; `ready_out` returns high on the wrap cycle.
- Back-pressure: hold `valid_in` with 32'hFFFF_FFFF while `ready_out`=0, then change to 32'hAAAA_AAAA before acceptance → only the value present at the transfer cycle is displayed.
- Blanking: `blank_in`=8'hF0, value 32'h8888_8888 → digits 4–7 give `cat_out`=7F, digits 0–3 give 7'h00.
- `LZ_BLANK`=1, value 32'h0000_00A0 → digits 2–7 are blank, digit1=A (7'h08), digit0=0 (7'h40). A value of 0 leaves only digit0 lit.
- Simultaneous transfer and wrap from IDLE → the data goes to pending and is displayed one full frame later. Asserting `rst_in` while PENDING → the old (reset) value stays displayed and `ready_out`=1.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Eight-digit common-anode seven-segment scan controller with a frame-aligned,
// tear-free update path and optional leading-zero blanking.

module bto7s (
    input  logic [3:0] x_in,
    output logic [6:0] s_out
);
    // Hex nibble to active-high segments {g,f,e,d,c,b,a}
    always_comb begin
        case (x_in)
            4'h0:    s_out = 7'h3F;
            4'h1:    s_out = 7'h06;
            4'h2:    s_out = 7'h5B;
            4'h3:    s_out = 7'h4F;
            4'h4:    s_out = 7'h66;
            4'h5:    s_out = 7'h6D;
            4'h6:    s_out = 7'h7D;
            4'h7:    s_out = 7'h07;
            4'h8:    s_out = 7'h7F;
            4'h9:    s_out = 7'h6F;
            4'hA:    s_out = 7'h77;
            4'hB:    s_out = 7'h7C;
            4'hC:    s_out = 7'h39;
            4'hD:    s_out = 7'h5E;
            4'hE:    s_out = 7'h79;
            4'hF:    s_out = 7'h71;
            default: s_out = 7'h00;
        endcase
    end
endmodule

module seg_scan_controller #(
    parameter int unsigned COUNT_PERIOD = 100000,
    parameter bit          LZ_BLANK     = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] val_in,
    input  logic [7:0]  blank_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  an_out,
    output logic [6:0]  cat_out,
    output logic [2:0]  digit_out
);
    localparam int unsigned CW = $clog2(COUNT_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_PERIOD - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   disp_val_q, disp_val_d;
    logic [7:0]    disp_blank_q, disp_blank_d;
    logic [31:0]   pend_val_q, pend_val_d;
    logic [7:0]    pend_blank_q, pend_blank_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    cat_q, cat_d;
    logic [2:0]    digit_q, digit_d;

    logic          period_end_s;
    logic          wrap_s;
    logic [3:0]    nibble_s;
    logic [6:0]    seg_s;
    logic [7:0]    lz_s;
    logic          zero_run_s;
    logic          blank_s;

    assign period_end_s = (cnt_q == CNT_LAST);
    assign wrap_s       = period_end_s && (idx_q == 3'd7);
    assign nibble_s     = disp_val_q[4*idx_q +: 4];

    bto7s u_bto7s (
        .x_in  (nibble_s),
        .s_out (seg_s)
    );

    // Scan counter and digit index
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (period_end_s) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Update handshake: pending data is applied only at the 7->0 wrap so a frame never mixes values
    always_comb begin
        state_d      = state_q;
        pend_val_d   = pend_val_q;
        pend_blank_d = pend_blank_q;
        disp_val_d   = disp_val_q;
        disp_blank_d = disp_blank_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    state_d      = ST_PENDING;
                    pend_val_d   = val_in;
                    pend_blank_d = blank_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (wrap_s) begin
                    state_d      = ST_IDLE;
                    disp_val_d   = pend_val_q;
                    disp_blank_d = pend_blank_q;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // lz_s[k] is set when nibbles k..7 of the displayed value are all zero
    always_comb begin
        zero_run_s = 1'b1;
        lz_s       = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            zero_run_s = zero_run_s & (disp_val_q[4*k +: 4] == 4'h0);
            lz_s[k]    = zero_run_s;
        end
    end

    // Decode of the current digit into the output register inputs
    always_comb begin
        blank_s = disp_blank_q[idx_q];
        if (LZ_BLANK && (idx_q != 3'd0) && lz_s[idx_q]) begin
            blank_s = 1'b1;
        end else begin
            blank_s = disp_blank_q[idx_q];
        end
        an_d    = ~(8'b0000_0001 << idx_q);
        digit_d = idx_q;
        if (blank_s) begin
            cat_d = 7'h7F;
        end else begin
            cat_d = ~seg_s;
        end
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            disp_val_q   <= 32'h0000_0000;
            disp_blank_q <= 8'h00;
            pend_val_q   <= 32'h0000_0000;
            pend_blank_q <= 8'h00;
            an_q         <= 8'hFF;
            cat_q        <= 7'h7F;
            digit_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            pend_val_q   <= pend_val_d;
            pend_blank_q <= pend_blank_d;
            an_q         <= an_d;
            cat_q        <= cat_d;
            digit_q      <= digit_d;
        end
    end

    assign ready_out = (state_q == ST_IDLE);
    assign an_out    = an_q;
    assign cat_out   = cat_q;
    assign digit_out = digit_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: two instances (leading-zero blanking off/on) against a
// time-based reference model driven by directed scenarios and random traffic.

module tb_seg_scan_controller;
    localparam int P     = 4;
    localparam int FRAME = 8 * P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] val = 32'h0;
    logic [7:0]  blank = 8'h0;
    logic        valid = 1'b0;
    logic        ready0, ready1;
    logic [7:0]  an0, an1;
    logic [6:0]  cat0, cat1;
    logic [2:0]  dig0, dig1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_controller #(.COUNT_PERIOD(P), .LZ_BLANK(1'b0)) dut0 (
        .clk_in(clk), .rst_in(rst), .val_in(val), .blank_in(blank), .valid_in(valid),
        .ready_out(ready0), .an_out(an0), .cat_out(cat0), .digit_out(dig0));

    seg_scan_controller #(.COUNT_PERIOD(P), .LZ_BLANK(1'b1)) dut1 (
        .clk_in(clk), .rst_in(rst), .val_in(val), .blank_in(blank), .valid_in(valid),
        .ready_out(ready1), .an_out(an1), .cat_out(cat1), .digit_out(dig1));

    // Active-low cathode pattern for each hex digit
    logic [6:0] cat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int          m_t = 0;
    bit          m_live = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_disp_val = 32'h0, m_pend_val = 32'h0;
    logic [7:0]  m_disp_blank = 8'h0, m_pend_blank = 8'h0;
    logic [7:0]  m_an = 8'hFF;
    logic [6:0]  m_cat0 = 7'h7F, m_cat1 = 7'h7F;
    logic [2:0]  m_dig = 3'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Effect of the coming clock edge, computed from elapsed cycles since reset
    task automatic model_step(input bit r, input bit v, input logic [31:0] vv, input logic [7:0] bb);
        int          idx;
        logic [7:0]  one;
        logic [31:0] upper;
        bit          b0, b1;
        one = 8'h01;
        if (r) begin
            m_live = 1'b1;
            m_t = 0;
            m_pend = 1'b0;
            m_disp_val = 32'h0;
            m_disp_blank = 8'h0;
            m_an = 8'hFF;
            m_cat0 = 7'h7F;
            m_cat1 = 7'h7F;
            m_dig = 3'd0;
        end else begin
            idx   = (m_t / P) % 8;
            upper = m_disp_val >> (4 * idx);
            b0    = m_disp_blank[idx];
            b1    = b0 || (idx != 0 && upper == 32'h0);
            m_an   = ~(one << idx);
            m_dig  = 3'(idx);
            m_cat0 = b0 ? 7'h7F : cat_tab[upper[3:0]];
            m_cat1 = b1 ? 7'h7F : cat_tab[upper[3:0]];
            if (m_pend && (m_t % FRAME) == FRAME - 1) begin
                m_pend = 1'b0;
                m_disp_val = m_pend_val;
                m_disp_blank = m_pend_blank;
            end else if (v && !m_pend) begin
                m_pend = 1'b1;
                m_pend_val = vv;
                m_pend_blank = bb;
            end
            m_t++;
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [31:0] vv, input logic [7:0] bb);
        rst = r; valid = v; val = vv; blank = bb;
        model_step(r, v, vv, bb);
        @(negedge clk);
        if (m_live) begin
            check_eq("an0", {24'h0, an0}, {24'h0, m_an});
            check_eq("cat0", {25'h0, cat0}, {25'h0, m_cat0});
            check_eq("digit0", {29'h0, dig0}, {29'h0, m_dig});
            check_eq("ready0", {31'h0, ready0}, {31'h0, !m_pend});
            check_eq("an1", {24'h0, an1}, {24'h0, m_an});
            check_eq("cat1", {25'h0, cat1}, {25'h0, m_cat1});
            check_eq("digit1", {29'h0, dig1}, {29'h0, m_dig});
            check_eq("ready1", {31'h0, ready1}, {31'h0, !m_pend});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 8'h0);
    endtask

    // Offer a value until it is accepted (bounded)
    task automatic send(input logic [31:0] vv, input logic [7:0] bb);
        int k;
        k = 0;
        while (m_pend && k < 4 * FRAME) begin
            cycle(1'b0, 1'b0, 32'h0, 8'h0);
            k++;
        end
        check_eq("send_timeout", {31'h0, m_pend}, 32'h0);
        cycle(1'b0, 1'b1, vv, bb);
    endtask

    initial begin
        int k;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 8'h0);
        idle(2 * FRAME + 4);

        idle(5);
        send(32'h0123_4567, 8'h00);
        idle(2 * FRAME);

        // Back-pressure: hold a value while busy, change it before acceptance
        send(32'h1111_1111, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 8'h00);
        k = 0;
        while (m_pend && k < 4 * FRAME) begin
            cycle(1'b0, 1'b1, 32'hAAAA_AAAA, 8'h00);
            k++;
        end
        cycle(1'b0, 1'b1, 32'hAAAA_AAAA, 8'h00);
        idle(3 * FRAME);

        send(32'h8888_8888, 8'hF0);
        idle(2 * FRAME + 2);
        send(32'h0000_00A0, 8'h00);
        idle(2 * FRAME + 2);
        send(32'h0000_0000, 8'h00);
        idle(2 * FRAME + 2);

        // Transfer coinciding with the wrap from idle
        k = 0;
        while ((m_pend || (m_t % FRAME) != FRAME - 1) && k < 4 * FRAME) begin
            cycle(1'b0, 1'b0, 32'h0, 8'h0);
            k++;
        end
        cycle(1'b0, 1'b1, 32'h5A5A_5A5A, 8'h0F);
        idle(2 * FRAME + 2);

        // Reset while pending discards the update
        send(32'h7654_3210, 8'h00);
        idle(3);
        cycle(1'b1, 1'b0, 32'h0, 8'h0);
        cycle(1'b1, 1'b0, 32'h0, 8'h0);
        idle(FRAME + 4);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rv;
            logic [7:0]  rb;
            rv = $urandom >> $urandom_range(0, 31);
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, rv, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
